// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer: pixel-tick divider, horizontal/vertical scan counters,
// registered scan decodes (x, y, pixel_on, syncs), frame_start pulse and a
// display-mode register that only changes on a frame boundary.
module vga_frame_sequencer #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int NUM_MODES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_next,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [1:0] mode
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [1:0] MODE_LAST = 2'(NUM_MODES - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             pending;
    logic             wrap_d1;

    logic tick;
    logic h_wrap;
    logic frame_wrap;
    logic pix_active;
    logic hs_active;
    logic vs_active;

    // Decode the tick, wrap conditions and active windows from the raw counters.
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        tick       = 1'b0;
        h_wrap     = 1'b0;
        frame_wrap = 1'b0;
        pix_active = 1'b0;
        hs_active  = 1'b0;
        vs_active  = 1'b0;

        tick       = (div_cnt == DIV_LAST);
        h_wrap     = tick && (h_cnt == H_LAST);
        frame_wrap = h_wrap && (v_cnt == V_LAST);
        pix_active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_active  = (h_cnt >= HS_START) && (h_cnt <= HS_END);
        vs_active  = (v_cnt >= VS_START) && (v_cnt <= VS_END);
    end

    // Clock divider: one pixel tick every CLK_DIV clk cycles.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Horizontal/vertical scan counters, advanced only on a pixel tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Registered scan decodes, one clk behind the counters and mutually aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            pixel_on <= 1'b0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
        end else begin
            x        <= h_cnt;
            y        <= v_cnt;
            pixel_on <= pix_active;
            hsync    <= hs_active ? SYNC_POL : ~SYNC_POL;
            vsync    <= vs_active ? SYNC_POL : ~SYNC_POL;
        end
    end

    // frame_start: the wrap is seen one clk before the counters read (0,0) and
    // two clks before x,y do, so it is delayed twice to line up with x,y.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_d1     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            wrap_d1     <= frame_wrap;
            frame_start <= wrap_d1;
        end
    end

    // Mode register: requests collapse into a pending flag that is consumed at
    // the next frame boundary; a request on the boundary itself counts there.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode    <= '0;
            pending <= 1'b0;
        end else if (frame_start) begin
            if (pending || mode_next) begin
                mode <= (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;
            end
            pending <= 1'b0;
        end else if (mode_next) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer using a scaled-down timing:
// CLK_DIV=2, H = 8+2+3+2 = 15, V = 4+1+2+1 = 8, so one line is 30 clk and one
// frame is 240 clk. k counts posedges since reset release; outputs are sampled
// 1 time unit after each posedge.
module tb_vga_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_next;
    logic [9:0] x;
    logic [9:0] y;
    logic       pixel_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;
    int k = 0;

    int cnt_pix;
    int cnt_hs;
    int cnt_vs;
    int cnt_fs;

    always #5 clk = ~clk;

    vga_frame_sequencer #(
        .CLK_DIV  (2),
        .H_VISIBLE(8),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (2),
        .V_VISIBLE(4),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .V_BACK   (1),
        .SYNC_POL (1'b0),
        .NUM_MODES(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_next  (mode_next),
        .x          (x),
        .y          (y),
        .pixel_on   (pixel_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start),
        .mode       (mode)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto(input int target);
        while (k < target) step();
    endtask

    // Request sampled on posedge kk+1.
    task automatic pulse_mode(input int kk);
        goto(kk);
        mode_next = 1'b1;
        step();
        mode_next = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"}, 32'(x), 0);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_pix"}, 32'(pixel_on), 0);
        check({tag, "_hs"}, 32'(hsync), 1);
        check({tag, "_vs"}, 32'(vsync), 1);
        check({tag, "_fs"}, 32'(frame_start), 0);
        check({tag, "_mode"}, 32'(mode), 0);
    endtask

    initial begin
        reset     = 1'b1;
        mode_next = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");

        reset = 1'b0;
        k     = 0;

        // First clk after release: visible pixel at (0,0), no frame_start.
        goto(1);
        check("k1_pix", 32'(pixel_on), 1);
        check("k1_x", 32'(x), 0);
        check("k1_fs", 32'(frame_start), 0);
        goto(2);
        check("k2_x", 32'(x), 0);
        goto(3);
        check("k3_x", 32'(x), 1);

        // Horizontal visible edge and hsync window [10,12].
        goto(16);
        check("x7_x", 32'(x), 7);
        check("x7_pix", 32'(pixel_on), 1);
        goto(17);
        check("x8_x", 32'(x), 8);
        check("x8_pix", 32'(pixel_on), 0);
        goto(20);
        check("x9_hs", 32'(hsync), 1);
        goto(21);
        check("x10_x", 32'(x), 10);
        check("x10_hs", 32'(hsync), 0);
        goto(26);
        check("x12_hs", 32'(hsync), 0);
        goto(27);
        check("x13_x", 32'(x), 13);
        check("x13_hs", 32'(hsync), 1);

        // Line wrap: x=14,y=0 then x=0,y=1 (30 clk per line).
        goto(30);
        check("lw_x14", 32'(x), 14);
        check("lw_y0", 32'(y), 0);
        goto(31);
        check("lw_x0", 32'(x), 0);
        check("lw_y1", 32'(y), 1);

        // Vertical visible edge and vsync window [5,6].
        goto(105);
        check("y3x7_pix", 32'(pixel_on), 1);
        goto(121);
        check("y4_y", 32'(y), 4);
        check("y4x0_pix", 32'(pixel_on), 0);
        goto(150);
        check("y4x14_vs", 32'(vsync), 1);
        goto(151);
        check("y5_y", 32'(y), 5);
        check("y5_vs", 32'(vsync), 0);
        goto(210);
        check("y6x14_vs", 32'(vsync), 0);
        goto(211);
        check("y7_y", 32'(y), 7);
        check("y7_vs", 32'(vsync), 1);

        // Frame wrap: frame_start coincides with the first (0,0) sample.
        goto(240);
        check("fw_pre_fs", 32'(frame_start), 0);
        goto(241);
        check("fw_fs", 32'(frame_start), 1);
        check("fw_x", 32'(x), 0);
        check("fw_y", 32'(y), 0);
        goto(242);
        check("fw_fs_off", 32'(frame_start), 0);
        check("fw_mode", 32'(mode), 0);

        // One full frame (k=243..482) of counts.
        cnt_pix = 0;
        cnt_hs  = 0;
        cnt_vs  = 0;
        cnt_fs  = 0;
        for (int i = 0; i < 240; i++) begin
            step();
            if (pixel_on) cnt_pix++;
            if (!hsync)   cnt_hs++;
            if (!vsync)   cnt_vs++;
            if (frame_start) begin
                cnt_fs++;
                check("fs_period", 32'(k), 481);
            end
        end
        check("cnt_pix", 32'(cnt_pix), 64);
        check("cnt_hs", 32'(cnt_hs), 48);
        check("cnt_vs", 32'(cnt_vs), 60);
        check("cnt_fs", 32'(cnt_fs), 1);
        check("mode_idle", 32'(mode), 0);

        // Two requests in one frame collapse to a single advance.
        pulse_mode(550);
        pulse_mode(600);
        goto(700);
        check("m_wait", 32'(mode), 0);
        goto(721);
        check("m_fs1", 32'(frame_start), 1);
        check("m_hold", 32'(mode), 0);
        goto(722);
        check("m_to1", 32'(mode), 1);

        // One request per frame: 2, 0, 1.
        pulse_mode(800);
        goto(962);
        check("m_to2", 32'(mode), 2);
        pulse_mode(1050);
        goto(1202);
        check("m_wrap0", 32'(mode), 0);
        pulse_mode(1300);
        goto(1442);
        check("m_to1b", 32'(mode), 1);

        // Request coincident with frame_start is consumed by that boundary.
        goto(1681);
        check("co_fs", 32'(frame_start), 1);
        mode_next = 1'b1;
        step();
        mode_next = 1'b0;
        check("co_mode", 32'(mode), 2);
        goto(1922);
        check("co_nocarry", 32'(mode), 2);

        // Reset mid-scan at x=1, y=2, mode=2.
        goto(1984);
        check("mid_x", 32'(x), 1);
        check("mid_y", 32'(y), 2);
        check("mid_pix", 32'(pixel_on), 1);
        reset = 1'b1;
        step();
        check_reset_state("midrst");
        reset = 1'b0;
        k     = 0;
        goto(1);
        check("re_pix", 32'(pixel_on), 1);
        check("re_fs", 32'(frame_start), 0);
        goto(3);
        check("re_x", 32'(x), 1);
        check("re_y", 32'(y), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
